inst_loader: RTL and testbench



---
 rtl/inst_loader_if.sv | 12 +
 rtl/inst_loader.sv | 189 ++++++++++++++++++
 tb/tb_inst_loader.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Instruction stream handshake (word, valid, ready) between the host side and inst_loader.
`timescale 1ns/1ps
interface inst_loader_if #(
    parameter int DataWidth = 32
) ();
    logic [DataWidth-1:0] inst_data;
    logic                 inst_valid;
    logic                 inst_ready;

    modport master (output inst_data, output inst_valid, input  inst_ready);
    modport slave  (input  inst_data, input  inst_valid, output inst_ready);
endinterface

// File: rtl/inst_loader.sv
// Streams instruction words through a small FIFO into the instruction memory write port.
// Define INST_LOADER_CHECKSUM_EN to get an XOR checksum of written words on checksum_o.
`timescale 1ns/1ps
module inst_loader #(
    parameter int RegAddrWidth     = 32,
    parameter int InstMemDepth     = 128,
    parameter int FifoDepth        = 4,
    parameter int InstMemAddrWidth = $clog2(InstMemDepth)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        start_i,
    input  logic [InstMemAddrWidth-1:0] base_addr_i,
    input  logic [InstMemAddrWidth:0]   num_words_i,
    input  logic                        pause_i,
    inst_loader_if.slave                inst_if,
    output logic [RegAddrWidth-1:0]     inst_wr_addr_o,
    output logic [RegAddrWidth-1:0]     inst_wr_data_o,
    output logic                        inst_wr_en_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [InstMemAddrWidth:0]   wr_count_o,
    output logic [RegAddrWidth-1:0]     checksum_o
);
    localparam int PtrWidth = $clog2(FifoDepth);
    localparam int CntWidth = InstMemAddrWidth + 1;
    localparam logic [CntWidth-1:0]           CntOne     = CntWidth'(1);
    localparam logic [PtrWidth:0]             PtrOne     = (PtrWidth + 1)'(1);
    localparam logic [InstMemAddrWidth+1:0]   DepthLimit = (InstMemAddrWidth + 2)'(InstMemDepth);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                      state_reg;
    logic [InstMemAddrWidth-1:0] base_reg;
    logic [CntWidth-1:0]         num_reg;
    logic [CntWidth-1:0]         accept_cnt_reg;
    logic [CntWidth-1:0]         wr_count_reg;
    logic [PtrWidth:0]           wr_ptr_reg;
    logic [PtrWidth:0]           rd_ptr_reg;
    logic [RegAddrWidth-1:0]     wr_addr_reg;
    logic [RegAddrWidth-1:0]     wr_data_reg;
    logic                        wr_en_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        error_reg;

    logic [InstMemAddrWidth+1:0] bound_sum;
    logic                        bound_err;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        ready_int;
    logic                        push;
    logic                        pop;
    logic [RegAddrWidth-1:0]     fifo_rd_word [FifoDepth];

    // Bound check is done one bit wider than the count so base + num cannot wrap.
    assign bound_sum = {2'b00, base_addr_i} + {1'b0, num_words_i};
    assign bound_err = bound_sum > DepthLimit;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PtrWidth] != rd_ptr_reg[PtrWidth]) &&
                        (wr_ptr_reg[PtrWidth-1:0] == rd_ptr_reg[PtrWidth-1:0]);

    assign ready_int = (state_reg == LOAD) && !fifo_full && (accept_cnt_reg < num_reg);
    assign push      = inst_if.inst_valid && ready_int;
    assign pop       = ((state_reg == LOAD) || (state_reg == DRAIN)) && !fifo_empty && !pause_i;

    genvar gi;
    generate
        for (gi = 0; gi < FifoDepth; gi++) begin : g_slot
            logic [RegAddrWidth-1:0] slot_reg;
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_reg[PtrWidth-1:0] == PtrWidth'(gi))) begin
                    slot_reg <= inst_if.inst_data;
                end
            end
            assign fifo_rd_word[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            num_reg        <= '0;
            accept_cnt_reg <= '0;
            wr_count_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            wr_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else if (clr_i) begin
            state_reg      <= IDLE;
            accept_cnt_reg <= '0;
            wr_count_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            wr_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            // busy trails the state by one cycle so it stays up through the done pulse.
            busy_reg  <= (state_reg != IDLE);

            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + PtrOne;
                accept_cnt_reg <= accept_cnt_reg + CntOne;
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + PtrOne;
                wr_en_reg    <= 1'b1;
                wr_addr_reg  <= RegAddrWidth'({1'b0, base_reg} + wr_count_reg);
                wr_data_reg  <= fifo_rd_word[rd_ptr_reg[PtrWidth-1:0]];
                wr_count_reg <= wr_count_reg + CntOne;
            end

            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (bound_err) begin
                            error_reg <= 1'b1;
                        end else if (num_words_i == '0) begin
                            busy_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            base_reg       <= base_addr_i;
                            num_reg        <= num_words_i;
                            accept_cnt_reg <= '0;
                            wr_count_reg   <= '0;
                            busy_reg       <= 1'b1;
                            state_reg      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (push && ((accept_cnt_reg + CntOne) == num_reg)) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (pop && ((wr_count_reg + CntOne) == num_reg)) state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic                    start_ok;
    logic [RegAddrWidth-1:0] checksum_reg;

    assign start_ok = (state_reg == IDLE) && start_i && !bound_err && (num_words_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_reg <= '0;
        end else if (clr_i || start_ok) begin
            checksum_reg <= '0;
        end else if (wr_en_reg) begin
            checksum_reg <= checksum_reg ^ wr_data_reg;
        end
    end

    assign checksum_o = checksum_reg;
`else
    assign checksum_o = '0;
`endif

    assign inst_if.inst_ready = ready_int;
    assign inst_wr_addr_o     = wr_addr_reg;
    assign inst_wr_data_o     = wr_data_reg;
    assign inst_wr_en_o       = wr_en_reg;
    assign busy_o             = busy_reg;
    assign done_o             = done_reg;
    assign error_o            = error_reg;
    assign wr_count_o         = wr_count_reg;
endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader; expected writes come from a base+index/word-list model.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int RW    = 32;
    localparam int Depth = 128;
    localparam int AW    = 7;

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          clr_i       = 1'b0;
    logic          start_i     = 1'b0;
    logic          pause_i     = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   num_words_i = '0;
    logic [RW-1:0] inst_wr_addr_o, inst_wr_data_o, checksum_o;
    logic          inst_wr_en_o, busy_o, done_o, error_o;
    logic [AW:0]   wr_count_o;

    inst_loader_if #(.DataWidth(RW)) inst_if ();

    inst_loader #(
        .RegAddrWidth(RW),
        .InstMemDepth(Depth),
        .FifoDepth   (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (clr_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_words_i   (num_words_i),
        .pause_i       (pause_i),
        .inst_if       (inst_if),
        .inst_wr_addr_o(inst_wr_addr_o),
        .inst_wr_data_o(inst_wr_data_o),
        .inst_wr_en_o  (inst_wr_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .wr_count_o    (wr_count_o),
        .checksum_o    (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cycle_cnt    = 0;
    logic [RW-1:0] words_q[$];
    int          wr_addr_q[$];
    logic [RW-1:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];
    int          err_cyc_q[$];
    int          accepted_n;
    int          first_acc_cyc;
    int          start_cyc;
    bit          abort_stream = 1'b0;

    // Write monitor: one line per memory write.
    always @(negedge clk_i) begin
        cycle_cnt++;
        if (inst_wr_en_o) begin
            wr_addr_q.push_back(int'(inst_wr_addr_o));
            wr_data_q.push_back(inst_wr_data_o);
            wr_cyc_q.push_back(cycle_cnt);
            $display("[TB] write cyc=%0d addr=%0d data=%08h", cycle_cnt, inst_wr_addr_o, inst_wr_data_o);
        end
        if (done_o)  done_cyc_q.push_back(cycle_cnt);
        if (error_o) err_cyc_q.push_back(cycle_cnt);
    end

    task automatic tick();
        @(negedge clk_i); #1;
    endtask

    task automatic clear_capture();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); err_cyc_q.delete();
    endtask

    task automatic make_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    function automatic logic [RW-1:0] exp_checksum(input int n);
        logic [RW-1:0] x = '0;
`ifdef INST_LOADER_CHECKSUM_EN
        for (int i = 0; i < n; i++) x ^= words_q[i];
`endif
        return x;
    endfunction

    task automatic start_load(input int base, input int num, output logic rdy_in_start);
        @(posedge clk_i); #1;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        num_words_i = (AW+1)'(num);
        start_cyc   = cycle_cnt + 1;
        @(negedge clk_i); #1;
        rdy_in_start = inst_if.inst_ready;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: valid ~70% random
    task automatic drive_stream(input int n, input int mode, input int budget);
        int idx = 0;
        int cyc = 0;
        accepted_n    = 0;
        first_acc_cyc = -1;
        while (idx < n && cyc < budget && !abort_stream) begin
            @(posedge clk_i); #1;
            case (mode)
                0:       inst_if.inst_valid = 1'b1;
                1:       inst_if.inst_valid = (cyc % 2 == 0);
                default: inst_if.inst_valid = ($urandom_range(99) < 70);
            endcase
            inst_if.inst_data = words_q[idx];
            @(negedge clk_i); #1;
            if (inst_if.inst_valid && inst_if.inst_ready) begin
                if (idx == 0) first_acc_cyc = cycle_cnt;
                idx++;
                accepted_n = idx;
            end
            cyc++;
        end
        @(posedge clk_i); #1;
        inst_if.inst_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done_cyc_q.size() == 0 && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        inst_if.inst_valid = 1'b0;
        inst_if.inst_data  = '0;
        repeat (3) tick();
        tests_run++;
        if ({inst_if.inst_ready, inst_wr_en_o, busy_o, done_o, error_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %05b expected 00000",
                     {inst_if.inst_ready, inst_wr_en_o, busy_o, done_o, error_o});
        end
        tests_run++;
        if (inst_wr_addr_o !== '0 || inst_wr_data_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0", inst_wr_addr_o, inst_wr_data_o);
        end
        tests_run++;
        if (wr_count_o !== '0 || checksum_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: got cnt=%0d sum=%h expected 0", wr_count_o, checksum_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        tick();
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_basic();
        logic rdy0;
        clear_capture();
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back(RW'(32'hA0 + i));
        start_load(0, 4, rdy0);
        tests_run++;
        if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_start: got %b expected 0", rdy0); end
        tick();
        tests_run++;
        if ({inst_if.inst_ready, busy_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL basic_ready_after: got ready,busy=%b%b expected 11", inst_if.inst_ready, busy_o);
        end
        drive_stream(4, 0, 50);
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 4) begin
            tests_failed++; $display("FAIL basic_count: got %0d expected 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            tests_run++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== words_q[i]) begin
                tests_failed++;
                $display("FAIL basic_word%0d: got addr=%0d data=%08h expected addr=%0d data=%08h",
                         i, wr_addr_q[i], wr_data_q[i], i, words_q[i]);
            end
        end
        if (wr_cyc_q.size() == 4) begin
            tests_run++;
            if (wr_cyc_q[3] - wr_cyc_q[0] !== 3) begin
                tests_failed++; $display("FAIL basic_throughput: got span %0d expected 3", wr_cyc_q[3] - wr_cyc_q[0]);
            end
            tests_run++;
            if (wr_cyc_q[0] !== first_acc_cyc + 2) begin
                tests_failed++; $display("FAIL basic_latency: got cyc %0d expected %0d", wr_cyc_q[0], first_acc_cyc + 2);
            end
        end
        tests_run++;
        if (done_cyc_q.size() !== 1 || (wr_cyc_q.size() > 0 && done_cyc_q.size() > 0 && done_cyc_q[0] !== wr_cyc_q[$] + 1)) begin
            tests_failed++; $display("FAIL basic_done: got %0d pulses expected 1 right after last write", done_cyc_q.size());
        end
        tests_run++;
        if (wr_count_o !== 4 || checksum_o !== exp_checksum(4) || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_status: got cnt=%0d sum=%h busy=%b expected cnt=4 sum=%h busy=1",
                     wr_count_o, checksum_o, busy_o, exp_checksum(4));
        end
        tick();
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_end: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_backpressure();
        logic rdy0;
        clear_capture();
        make_words(6);
        pause_i = 1'b1;
        start_load(10, 6, rdy0);
        fork
            drive_stream(6, 0, 100);
            begin
                repeat (8) @(posedge clk_i);
                @(negedge clk_i); #2;
                tests_run++;
                if (accepted_n !== 4 || inst_if.inst_ready !== 1'b0 || wr_addr_q.size() !== 0) begin
                    tests_failed++;
                    $display("FAIL bp_full: got accepted=%0d ready=%b writes=%0d expected 4 0 0",
                             accepted_n, inst_if.inst_ready, wr_addr_q.size());
                end
                pause_i = 1'b0;
            end
        join
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 6 || done_cyc_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL bp_count: got writes=%0d done=%0d expected 6 1", wr_addr_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
            tests_run++;
            if (wr_addr_q[i] !== 10 + i || wr_data_q[i] !== words_q[i]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got addr=%0d data=%08h expected addr=%0d data=%08h",
                         i, wr_addr_q[i], wr_data_q[i], 10 + i, words_q[i]);
            end
        end
        tests_run++;
        if (wr_count_o !== 6 || checksum_o !== exp_checksum(6)) begin
            tests_failed++;
            $display("FAIL bp_status: got cnt=%0d sum=%h expected 6 %h", wr_count_o, checksum_o, exp_checksum(6));
        end
    endtask

    task automatic test_bound();
        logic rdy0;
        int   busy_seen = 0;
        clear_capture();
        start_load(126, 3, rdy0);
        repeat (6) begin
            tick();
            if (busy_o) busy_seen++;
        end
        tests_run++;
        if (err_cyc_q.size() !== 1 || (err_cyc_q.size() > 0 && err_cyc_q[0] !== start_cyc + 1)) begin
            tests_failed++;
            $display("FAIL bound_error: got %0d pulses expected 1 at cyc %0d", err_cyc_q.size(), start_cyc + 1);
        end
        tests_run++;
        if (busy_seen !== 0 || wr_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bound_quiet: got busy_cycles=%0d writes=%0d expected 0 0", busy_seen, wr_addr_q.size());
        end
        clear_capture();
        make_words(3);
        start_load(125, 3, rdy0);
        drive_stream(3, 0, 50);
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 3 || err_cyc_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bound_edge_count: got writes=%0d errors=%0d expected 3 0", wr_addr_q.size(), err_cyc_q.size());
        end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            tests_run++;
            if (wr_addr_q[i] !== 125 + i || wr_data_q[i] !== words_q[i]) begin
                tests_failed++;
                $display("FAIL bound_edge_word%0d: got addr=%0d data=%08h expected addr=%0d data=%08h",
                         i, wr_addr_q[i], wr_data_q[i], 125 + i, words_q[i]);
            end
        end
    endtask

    task automatic test_zero();
        logic rdy0;
        clear_capture();
        start_load($urandom_range(0, 127), 0, rdy0);
        wait_done(20);
        tests_run++;
        if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== start_cyc + 2)) begin
            tests_failed++;
            $display("FAIL zero_done: got %0d pulses expected 1 at cyc %0d", done_cyc_q.size(), start_cyc + 2);
        end
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL zero_busy_done: got %b expected 1", busy_o); end
        repeat (3) tick();
        tests_run++;
        if (wr_addr_q.size() !== 0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_quiet: got writes=%0d busy=%b expected 0 0", wr_addr_q.size(), busy_o);
        end
    endtask

    task automatic test_gapped();
        logic rdy0;
        int   base = $urandom_range(0, 123);
        int   viol = 0;
        int   c    = 0;
        clear_capture();
        make_words(5);
        start_load(base, 5, rdy0);
        drive_stream(5, 1, 100);
        while (done_cyc_q.size() == 0 && c < 50) begin
            tick();
            if (inst_if.inst_ready) viol++;
            c++;
        end
        tests_run++;
        if (viol !== 0) begin tests_failed++; $display("FAIL gap_drain_ready: got %0d ready cycles expected 0", viol); end
        tests_run++;
        if (wr_addr_q.size() !== 5 || done_cyc_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL gap_count: got writes=%0d done=%0d expected 5 1", wr_addr_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            tests_run++;
            if (wr_addr_q[i] !== base + i || wr_data_q[i] !== words_q[i]) begin
                tests_failed++;
                $display("FAIL gap_word%0d: got addr=%0d data=%08h expected addr=%0d data=%08h",
                         i, wr_addr_q[i], wr_data_q[i], base + i, words_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic rdy0;
        int   base = $urandom_range(0, 100);
        clear_capture();
        make_words(6);
        start_load(base, 6, rdy0);
        fork
            drive_stream(6, 0, 60);
            begin
                int c = 0;
                while (wr_addr_q.size() < 2 && c < 60) begin tick(); c++; end
                @(posedge clk_i); #1; clr_i = 1'b1;
                @(posedge clk_i); #1; clr_i = 1'b0;
                tick();
                tests_run++;
                if ({busy_o, inst_wr_en_o, inst_if.inst_ready} !== 3'b000 || wr_count_o !== '0 || checksum_o !== '0) begin
                    tests_failed++;
                    $display("FAIL clr_state: got busy,wr_en,ready=%b%b%b cnt=%0d sum=%h expected 000 0 0",
                             busy_o, inst_wr_en_o, inst_if.inst_ready, wr_count_o, checksum_o);
                end
                abort_stream = 1'b1;
            end
        join
        abort_stream = 1'b0;
        clear_capture();
        make_words(4);
        base = $urandom_range(0, 124);
        start_load(base, 4, rdy0);
        drive_stream(4, 0, 50);
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 4 || wr_count_o !== 4 || checksum_o !== exp_checksum(4)) begin
            tests_failed++;
            $display("FAIL clr_reload: got writes=%0d cnt=%0d sum=%h expected 4 4 %h",
                     wr_addr_q.size(), wr_count_o, checksum_o, exp_checksum(4));
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            tests_run++;
            if (wr_addr_q[i] !== base + i || wr_data_q[i] !== words_q[i]) begin
                tests_failed++;
                $display("FAIL clr_word%0d: got addr=%0d data=%08h expected addr=%0d data=%08h",
                         i, wr_addr_q[i], wr_data_q[i], base + i, words_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic rdy0;
        for (int it = 0; it < 6; it++) begin
            int num  = $urandom_range(1, 12);
            int base = $urandom_range(0, Depth - num);
            int bad  = 0;
            clear_capture();
            make_words(num);
            start_load(base, num, rdy0);
            fork
                drive_stream(num, 2, 400);
                begin
                    int c = 0;
                    while (done_cyc_q.size() == 0 && c < 600) begin
                        @(posedge clk_i); #1;
                        pause_i = ($urandom_range(3) == 0);
                        c++;
                    end
                    pause_i = 1'b0;
                end
            join
            wait_done(50);
            for (int i = 0; i < num && i < wr_addr_q.size(); i++) begin
                if (wr_addr_q[i] !== base + i || wr_data_q[i] !== words_q[i]) bad++;
            end
            tests_run++;
            if (wr_addr_q.size() !== num || bad !== 0) begin
                tests_failed++;
                $display("FAIL b2b_%0d_writes: got %0d writes %0d wrong expected %0d writes 0 wrong",
                         it, wr_addr_q.size(), bad, num);
            end
            tests_run++;
            if (done_cyc_q.size() !== 1 || wr_count_o !== num || checksum_o !== exp_checksum(num) ||
                (wr_cyc_q.size() > 0 && done_cyc_q.size() > 0 && done_cyc_q[0] !== wr_cyc_q[$] + 1)) begin
                tests_failed++;
                $display("FAIL b2b_%0d_status: got done=%0d cnt=%0d sum=%h expected 1 %0d %h",
                         it, done_cyc_q.size(), wr_count_o, checksum_o, num, exp_checksum(num));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bound();
        test_zero();
        test_gapped();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
